// File: rtl/work_loader.sv
// work_loader: receives an 80-byte mining job over a UART line (8N1, LSB first)
// and presents it as two SHA-256 message blocks with a valid/ack handshake.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rxd          UART serial input, idle high, asynchronous to clock
//   blk1         header bytes 0..63 (byte 0 in the MSBs)
//   blk2         header bytes 64..79, 0x80 pad, zero fill, 640-bit length
//   work_valid   blk1/blk2 hold a complete job not yet acknowledged
//   work_ack     consumer accepts the job
//   busy         a frame is partially received
//   frame_error  one-cycle pulse when a partial frame is discarded
//   overrun      one-cycle pulse when a complete frame is dropped
module work_loader #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         rxd,
   output logic [511:0] blk1,
   output logic [511:0] blk2,
   output logic         work_valid,
   input  logic         work_ack,
   output logic         busy,
   output logic         frame_error,
   output logic         overrun
);

   localparam int unsigned TMR_W      = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF_BIT   = CLKS_PER_BIT / 2;
   localparam int unsigned TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TO_W       = $clog2(TO_CYCLES + 1);
   localparam int unsigned HDR_BYTES  = 80;
   localparam int unsigned HDR_W      = HDR_BYTES * 8;
   localparam int unsigned CNT_W      = 7;
   localparam int unsigned IDX_W      = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } rx_state_t;

   rx_state_t         state;
   logic              rxd_meta;
   logic              rxd_sync;
   logic [TMR_W-1:0]  timer;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic [CNT_W-1:0]  byte_cnt;
   logic [TO_W-1:0]   idle_cnt;
   logic [HDR_W-1:0]  hdr;
   logic              frame_done;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   // Receiver FSM, byte assembly and inter-byte timeout.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         timer       <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         byte_cnt    <= '0;
         idle_cnt    <= '0;
         hdr         <= '0;
         busy        <= 1'b0;
         frame_error <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         frame_done  <= 1'b0;
         idle_cnt    <= '0;
         case (state)
            S_IDLE: begin
               timer <= '0;
               if (!rxd_sync) begin
                  state <= S_START;
               end
               // Only a partially received frame can time out.
               if (byte_cnt != '0) begin
                  if (idle_cnt == TO_W'(TO_CYCLES - 1)) begin
                     byte_cnt    <= '0;
                     busy        <= 1'b0;
                     frame_error <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt + TO_W'(1);
                  end
               end
            end
            S_START: begin
               if (timer == TMR_W'(HALF_BIT - 1)) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  // High at mid start bit is a glitch, not a byte.
                  state   <= rxd_sync ? S_IDLE : S_DATA;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_DATA: begin
               if (timer == TMR_W'(CLKS_PER_BIT - 1)) begin
                  timer   <= '0;
                  shreg   <= {rxd_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_STOP: begin
               if (timer == TMR_W'(CLKS_PER_BIT - 1)) begin
                  timer <= '0;
                  state <= S_IDLE;
                  if (rxd_sync) begin
                     hdr[IDX_W'(HDR_W - 1) - (IDX_W'(byte_cnt) << 3) -: 8] <= shreg;
                     if (byte_cnt == CNT_W'(HDR_BYTES - 1)) begin
                        byte_cnt   <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                     end else begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        busy     <= 1'b1;
                     end
                  end else begin
                     byte_cnt    <= '0;
                     busy        <= 1'b0;
                     frame_error <= 1'b1;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Job handoff: frame_done follows the final commit by one cycle, so hdr
   // already holds byte 79 here and cannot change before the next byte.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blk1       <= '0;
         blk2       <= '0;
         work_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (frame_done) begin
            if (!work_valid || work_ack) begin
               blk1       <= hdr[HDR_W-1:128];
               blk2       <= {hdr[127:0], 8'h80, 312'd0, 64'h0000000000000280};
               work_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (work_valid && work_ack) begin
            work_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_work_loader.sv
module tb_work_loader;

   localparam int unsigned CPB = 4;
   localparam int unsigned TOB = 20;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         rxd;
   logic [511:0] blk1;
   logic [511:0] blk2;
   logic         work_valid;
   logic         work_ack;
   logic         busy;
   logic         frame_error;
   logic         overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;

   logic [7:0] frame [80];

   work_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clock(clock), .reset_n(reset_n), .rxd(rxd),
      .blk1(blk1), .blk2(blk2), .work_valid(work_valid), .work_ack(work_ack),
      .busy(busy), .frame_error(frame_error), .overrun(overrun)
   );

   always #5 clock = ~clock;

   // Pulse counters, sampled away from the active edge.
   always @(negedge clock) begin
      if (reset_n) begin
         if (frame_error) fe_cnt++;
         if (overrun) ov_cnt++;
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One 8N1 character, LSB first; bad_stop drives the stop bit low.
   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      @(negedge clock);
      rxd = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clock);
      end
      rxd = bad_stop ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clock);
      rxd = 1'b1;
   endtask

   task automatic send_bytes(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         send_byte(frame[i], 1'b0);
         idle_cycles(int'($urandom_range(0, 12)));
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 80; i++) frame[i] = 8'($urandom);
   endtask

   // Reference: SHA-256 padding of the 640-bit header into two blocks.
   task automatic model(output logic [511:0] e1, output logic [511:0] e2);
      e1 = '0;
      e2 = '0;
      for (int i = 0; i < 64; i++) e1[511 - 8*i -: 8] = frame[i];
      for (int i = 64; i < 80; i++) e2[511 - 8*(i-64) -: 8] = frame[i];
      e2[383:376] = 8'h80;
      e2[63:0]    = 64'd640;
   endtask

   task automatic wait_valid(output bit got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (work_valid) got = 1'b1;
         else @(negedge clock);
      end
   endtask

   task automatic ack_job();
      @(negedge clock);
      work_ack = 1'b1;
      @(negedge clock);
      work_ack = 1'b0;
   endtask

   task automatic test_reset();
      logic [511:0] z = '0;
      reset_n  = 1'b0;
      rxd      = 1'b1;
      work_ack = 1'b0;
      idle_cycles(3);
      n_checks++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", work_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_error); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
      n_checks++; if (blk1 !== z) begin n_fail++; $display("FAIL reset_blk1: got %h expected 0", blk1); end
      n_checks++; if (blk2 !== z) begin n_fail++; $display("FAIL reset_blk2: got %h expected 0", blk2); end
      reset_n = 1'b1;
      idle_cycles(4);
   endtask

   task automatic test_known_frame();
      logic [511:0] e1, e2;
      bit got;
      int fe0 = fe_cnt;
      for (int i = 0; i < 80; i++) frame[i] = 8'(i);
      model(e1, e2);
      send_bytes(0, 79);
      wait_valid(got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL known_valid: got 0 expected 1"); end
      n_checks++; if (blk1 !== e1) begin n_fail++; $display("FAIL known_blk1: got %h expected %h", blk1, e1); end
      n_checks++; if (blk2 !== e2) begin n_fail++; $display("FAIL known_blk2: got %h expected %h", blk2, e2); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL known_busy: got %b expected 0", busy); end
      n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL known_ferr: got %0d expected 0", fe_cnt - fe0); end
      ack_job();
      n_checks++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL known_ack: got %b expected 0", work_valid); end
   endtask

   task automatic test_random_frames();
      logic [511:0] e1, e2;
      bit got;
      for (int f = 0; f < 3; f++) begin
         rand_frame();
         model(e1, e2);
         send_bytes(0, 79);
         wait_valid(got);
         n_checks++; if (!got) begin n_fail++; $display("FAIL rand_valid[%0d]: got 0 expected 1", f); end
         n_checks++; if (blk1 !== e1) begin n_fail++; $display("FAIL rand_blk1[%0d]: got %h expected %h", f, blk1, e1); end
         n_checks++; if (blk2 !== e2) begin n_fail++; $display("FAIL rand_blk2[%0d]: got %h expected %h", f, blk2, e2); end
         ack_job();
         n_checks++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL rand_ack[%0d]: got %b expected 0", f, work_valid); end
      end
   endtask

   task automatic test_stop_error();
      logic [511:0] e1, e2;
      bit got;
      int fe0;
      rand_frame();
      send_bytes(0, 9);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_busy_pre: got %b expected 1", busy); end
      fe0 = fe_cnt;
      send_byte(frame[10], 1'b1);
      idle_cycles(3 * CPB);
      n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL stop_ferr: got %0d expected 1", fe_cnt - fe0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
      n_checks++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL stop_valid: got %b expected 0", work_valid); end
      rand_frame();
      model(e1, e2);
      send_bytes(0, 79);
      wait_valid(got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL stop_recover_valid: got 0 expected 1"); end
      n_checks++; if (blk1 !== e1) begin n_fail++; $display("FAIL stop_recover_blk1: got %h expected %h", blk1, e1); end
      n_checks++; if (blk2 !== e2) begin n_fail++; $display("FAIL stop_recover_blk2: got %h expected %h", blk2, e2); end
      ack_job();
   endtask

   task automatic test_back_to_back();
      logic [511:0] e1, e2;
      bit got;
      int ov0;
      rand_frame();
      model(e1, e2);
      send_bytes(0, 79);
      wait_valid(got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL b2b_valid: got 0 expected 1"); end
      ov0 = ov_cnt;
      rand_frame();
      send_bytes(0, 79);
      idle_cycles(10);
      n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 1", ov_cnt - ov0); end
      n_checks++; if (work_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_still_valid: got %b expected 1", work_valid); end
      n_checks++; if (blk1 !== e1) begin n_fail++; $display("FAIL b2b_blk1: got %h expected %h", blk1, e1); end
      n_checks++; if (blk2 !== e2) begin n_fail++; $display("FAIL b2b_blk2: got %h expected %h", blk2, e2); end
      ack_job();
      n_checks++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack: got %b expected 0", work_valid); end
   endtask

   task automatic test_timeout();
      logic [511:0] e1, e2;
      bit got;
      int fe0;
      rand_frame();
      send_bytes(0, 39);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_pre: got %b expected 1", busy); end
      fe0 = fe_cnt;
      idle_cycles(21 * CPB);
      n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL to_ferr: got %0d expected 1", fe_cnt - fe0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b expected 0", busy); end
      rand_frame();
      model(e1, e2);
      send_bytes(0, 79);
      wait_valid(got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL to_recover_valid: got 0 expected 1"); end
      n_checks++; if (blk1 !== e1) begin n_fail++; $display("FAIL to_recover_blk1: got %h expected %h", blk1, e1); end
      n_checks++; if (blk2 !== e2) begin n_fail++; $display("FAIL to_recover_blk2: got %h expected %h", blk2, e2); end
      ack_job();
   endtask

   task automatic test_glitch();
      int busy_seen = 0;
      int fe0 = fe_cnt;
      @(negedge clock);
      rxd = 1'b0;
      @(negedge clock);
      rxd = 1'b1;
      for (int i = 0; i < 6 * CPB; i++) begin
         @(negedge clock);
         if (busy) busy_seen++;
      end
      n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_seen); end
      n_checks++; if (fe_cnt - fe0 != 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - fe0); end
   endtask

   task automatic test_reset_mid();
      logic [511:0] e1, e2;
      logic [511:0] z = '0;
      bit got;
      rand_frame();
      send_bytes(0, 79);
      wait_valid(got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL rmid_pre_valid: got 0 expected 1"); end
      rand_frame();
      send_bytes(0, 30);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      n_checks++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", work_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      n_checks++; if (blk1 !== z) begin n_fail++; $display("FAIL rmid_blk1: got %h expected 0", blk1); end
      n_checks++; if (blk2 !== z) begin n_fail++; $display("FAIL rmid_blk2: got %h expected 0", blk2); end
      n_checks++; if ({frame_error, overrun} !== 2'b00) begin n_fail++; $display("FAIL rmid_pulses: got %b expected 00", {frame_error, overrun}); end
      idle_cycles(3);
      reset_n = 1'b1;
      idle_cycles(4);
      rand_frame();
      model(e1, e2);
      send_bytes(0, 79);
      wait_valid(got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL rmid_post_valid: got 0 expected 1"); end
      n_checks++; if (blk1 !== e1) begin n_fail++; $display("FAIL rmid_post_blk1: got %h expected %h", blk1, e1); end
      n_checks++; if (blk2 !== e2) begin n_fail++; $display("FAIL rmid_post_blk2: got %h expected %h", blk2, e2); end
      ack_job();
   endtask

   initial begin
      test_reset();
      test_known_frame();
      test_random_frames();
      test_stop_error();
      test_back_to_back();
      test_timeout();
      test_glitch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
